// File: rtl/pwm_sine_pkg.sv
// -----------------------------------------------------------------------------
// pwm_sine_pkg
// Shared definitions for the UART-driven sine PWM control block:
//   - command byte codes understood by the frame parser
//   - response codes returned through the UART transmitter
//   - parser state encoding
//   - preset phase-increment table selected by the two board switches
// No ports; imported by pwm_sine_cmd_ctrl and pwm_sine_phase_acc.
// -----------------------------------------------------------------------------
package pwm_sine_pkg;

    // Command bytes (first byte of a 3-byte frame)
    localparam logic [7:0] CMD_FREQ = 8'h46;  // 'F' : set phase increment
    localparam logic [7:0] CMD_AMP  = 8'h41;  // 'A' : set amplitude
    localparam logic [7:0] CMD_EN   = 8'h45;  // 'E' : generator enable
    localparam logic [7:0] CMD_STAT = 8'h53;  // 'S' : read back amplitude

    // Response bytes
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    // Width of the preset increment table entries
    localparam int PRESET_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GOT_CMD,
        ST_GOT_HI,
        ST_EXEC,
        ST_RESP
    } parse_state_t;

    // Preset tone table indexed by {sw_1, sw_0}; each step doubles the pitch.
    function automatic logic [PRESET_W-1:0] preset_inc(input logic [1:0] sel);
        logic [PRESET_W-1:0] val;
        case (sel)
            2'b00:   val = 16'h0040;
            2'b01:   val = 16'h0080;
            2'b10:   val = 16'h0100;
            default: val = 16'h0200;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/pwm_sine_phase_acc.sv
// -----------------------------------------------------------------------------
// pwm_sine_phase_acc
// Sine phase accumulator. Each PWM period end (step) advances the phase by
// inc, wrapping modulo 2^PHASE_W, and raises sample_req for exactly one cycle
// so the datapath loads the new LUT sample into the PWM compare register.
// While en is low the phase is held at zero and steps are ignored.
//
// Ports
//   clk1        in   1        system clock, rising edge
//   rst         in   1        synchronous active-high reset
//   inc         in   PHASE_W  phase increment applied on each step
//   step        in   1        1-cycle strobe at end of PWM period
//   en          in   1        generator enable
//   phase       out  PHASE_W  accumulator value
//   sample_req  out  1        1-cycle strobe, the cycle after an accepted step
// -----------------------------------------------------------------------------
module pwm_sine_phase_acc #(
    parameter int PHASE_W = 16
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic [PHASE_W-1:0] inc,
    input  logic               step,
    input  logic               en,
    output logic [PHASE_W-1:0] phase,
    output logic               sample_req
);

    logic [PHASE_W-1:0] phase_reg;
    logic               sample_req_reg;

    always_ff @(posedge clk1) begin
        if (rst) begin
            phase_reg      <= '0;
            sample_req_reg <= 1'b0;
        end else if (!en) begin
            // Disabled generator parks the phase at the start of the table
            phase_reg      <= '0;
            sample_req_reg <= 1'b0;
        end else if (step) begin
            // Natural wrap: the carry out of the adder is dropped
            phase_reg      <= phase_reg + inc;
            sample_req_reg <= 1'b1;
        end else begin
            sample_req_reg <= 1'b0;
        end
    end

    assign phase      = phase_reg;
    assign sample_req = sample_req_reg;

endmodule

// File: rtl/pwm_sine_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_sine_cmd_ctrl
// Control and sequencing for the UART-driven sine PWM. Parses 3-byte command
// frames (CMD, D_HI, D_LO) from the UART receiver, owns the configuration
// registers (phase increment, amplitude, enable), drives the phase
// accumulator and answers every complete frame through the UART transmitter.
// When no UART frequency override is active the two switches pick a preset tone.
//
// Ports
//   clk1           in   1        system clock, rising edge
//   rst            in   1        synchronous active-high reset
//   rx_data        in   8        byte from UART RX
//   rx_valid       in   1        1-cycle strobe, rx_data valid
//   tx_data        out  8        response byte to UART TX
//   tx_valid       out  1        response pending, held until tx_ready
//   tx_ready       in   1        UART TX accepts byte on tx_valid & tx_ready
//   sw_0, sw_1     in   1        asynchronous preset-select switches
//   pwm_cycle_end  in   1        1-cycle strobe at end of each PWM period
//   phase          out  PHASE_W  accumulator; LUT address = phase[PHASE_W-1 -: 8]
//   amplitude      out  AMP_W    amplitude scale to the sine datapath
//   gen_en         out  1        generator enable
//   sample_req     out  1        1-cycle strobe: load new sample into PWM compare
// -----------------------------------------------------------------------------
module pwm_sine_cmd_ctrl
    import pwm_sine_pkg::*;
#(
    parameter int               PHASE_W  = 16,
    parameter int               AMP_W    = 8,
    parameter logic [AMP_W-1:0] AMP_RST  = 8'h80,
    parameter int               FRAME_TO = 1000
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic               sw_0,
    input  logic               sw_1,
    input  logic               pwm_cycle_end,
    output logic [PHASE_W-1:0] phase,
    output logic [AMP_W-1:0]   amplitude,
    output logic               gen_en,
    output logic               sample_req
);

    localparam int           TO_W    = $clog2(FRAME_TO + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FRAME_TO - 1);

    // -------------------------------------------------------------------------
    // Switch synchronisers (two flops per switch)
    // -------------------------------------------------------------------------
    logic [1:0] sw_raw;
    logic [1:0] sw_sync;

    assign sw_raw = {sw_1, sw_0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sw_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk1) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= sw_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign sw_sync[gi] = sync_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Frame parser, configuration registers and response
    // -------------------------------------------------------------------------
    parse_state_t        state_reg;
    logic [7:0]          cmd_reg;
    logic [7:0]          hi_reg;
    logic [7:0]          lo_reg;
    logic [TO_W-1:0]     to_cnt_reg;
    logic [7:0]          tx_data_reg;
    logic                tx_valid_reg;
    logic [PHASE_W-1:0]  inc_reg;
    logic                override_reg;
    logic [AMP_W-1:0]    amp_reg;
    logic                gen_en_reg;
    logic [15:0]         data_word;

    assign data_word = {hi_reg, lo_reg};

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cmd_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            to_cnt_reg   <= '0;
            tx_data_reg  <= '0;
            tx_valid_reg <= 1'b0;
            inc_reg      <= '0;
            override_reg <= 1'b0;
            amp_reg      <= AMP_RST;
            gen_en_reg   <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (rx_valid) begin
                        cmd_reg    <= rx_data;
                        to_cnt_reg <= '0;
                        state_reg  <= ST_GOT_CMD;
                    end
                end

                // Inter-byte timeout: the counter restarts on every byte and a
                // stalled frame is dropped silently after FRAME_TO idle cycles.
                ST_GOT_CMD: begin
                    if (rx_valid) begin
                        hi_reg     <= rx_data;
                        to_cnt_reg <= '0;
                        state_reg  <= ST_GOT_HI;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg  <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end

                ST_GOT_HI: begin
                    if (rx_valid) begin
                        lo_reg     <= rx_data;
                        to_cnt_reg <= '0;
                        state_reg  <= ST_EXEC;
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg  <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end

                // Bytes arriving in EXEC/RESP are not captured anywhere, so
                // they are dropped rather than queued.
                ST_EXEC: begin
                    case (cmd_reg)
                        CMD_FREQ: begin
                            // A zero increment is the "return to switches" code
                            if (data_word == 16'h0000) begin
                                override_reg <= 1'b0;
                            end else begin
                                inc_reg      <= PHASE_W'(data_word);
                                override_reg <= 1'b1;
                            end
                            tx_data_reg <= RSP_ACK;
                        end
                        CMD_AMP: begin
                            amp_reg     <= AMP_W'(lo_reg);
                            tx_data_reg <= RSP_ACK;
                        end
                        CMD_EN: begin
                            gen_en_reg  <= lo_reg[0];
                            tx_data_reg <= RSP_ACK;
                        end
                        CMD_STAT: begin
                            tx_data_reg <= 8'(amp_reg);
                        end
                        default: begin
                            tx_data_reg <= RSP_NAK;
                        end
                    endcase
                    tx_valid_reg <= 1'b1;
                    state_reg    <= ST_RESP;
                end

                ST_RESP: begin
                    if (tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Phase accumulator. eff_inc comes straight from the current registers, so
    // an increment written in the same cycle as a step only applies from the
    // following step.
    // -------------------------------------------------------------------------
    logic [PHASE_W-1:0] eff_inc;

    assign eff_inc = override_reg ? inc_reg : PHASE_W'(preset_inc(sw_sync));

    pwm_sine_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .clk1       (clk1),
        .rst        (rst),
        .inc        (eff_inc),
        .step       (pwm_cycle_end),
        .en         (gen_en_reg),
        .phase      (phase),
        .sample_req (sample_req)
    );

    assign tx_data   = tx_data_reg;
    assign tx_valid  = tx_valid_reg;
    assign amplitude = amp_reg;
    assign gen_en    = gen_en_reg;

endmodule

// File: tb/tb_pwm_sine_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_sine_cmd_ctrl
// Directed bench for pwm_sine_cmd_ctrl. Inputs change 1 ns after the rising
// edge; outputs are checked at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pwm_sine_cmd_ctrl;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        sw_0 = 1'b0;
    logic        sw_1 = 1'b0;
    logic        pwm_cycle_end = 1'b0;
    logic [15:0] phase;
    logic [7:0]  amplitude;
    logic        gen_en;
    logic        sample_req;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk1 = ~clk1;

    pwm_sine_cmd_ctrl dut (
        .clk1          (clk1),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .sw_0          (sw_0),
        .sw_1          (sw_1),
        .pwm_cycle_end (pwm_cycle_end),
        .phase         (phase),
        .amplitude     (amplitude),
        .gen_en        (gen_en),
        .sample_req    (sample_req)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("[TB] check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Leaves the bench in the first RESP cycle (tx_valid should be high)
    task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
        send_byte(c);
        send_byte(h);
        send_byte(l);
        tick();
    endtask

    task automatic handshake();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic strobe();
        pwm_cycle_end = 1'b1;
        tick();
        pwm_cycle_end = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        rst = 1'b1;
        repeat (3) tick();
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_phase", 32'(phase), 32'h0000);
        check("rst_amplitude", 32'(amplitude), 32'h80);
        check("rst_gen_en", 32'(gen_en), 32'h1);
        check("rst_sample_req", 32'(sample_req), 32'h0);
        rst = 1'b0;
        repeat (3) tick();

        // ---------------- preset 00 stepping ----------------
        check("p00_phase0", 32'(phase), 32'h0000);
        strobe();
        check("p00_phase1", 32'(phase), 32'h0040);
        check("p00_req1", 32'(sample_req), 32'h1);
        tick();
        check("p00_req1_off", 32'(sample_req), 32'h0);
        strobe();
        check("p00_phase2", 32'(phase), 32'h0080);
        tick();
        strobe();
        check("p00_phase3", 32'(phase), 32'h00C0);
        tick();
        check("p00_req3_off", 32'(sample_req), 32'h0);
        strobe();
        check("p00_phase4", 32'(phase), 32'h0100);
        check("p00_req4", 32'(sample_req), 32'h1);
        tick();

        // ---------------- F 12 34 override ----------------
        send_frame(8'h46, 8'h12, 8'h34);
        check("f1234_valid", 32'(tx_valid), 32'h1);
        check("f1234_data", 32'(tx_data), 32'h06);
        repeat (3) tick();
        check("f1234_hold_v", 32'(tx_valid), 32'h1);
        check("f1234_hold_d", 32'(tx_data), 32'h06);
        handshake();
        check("f1234_done", 32'(tx_valid), 32'h0);
        strobe();
        check("f1234_phase", 32'(phase), 32'h1334);
        tick();

        // ---------------- F 00 00 clears override; sw=11 ----------------
        send_frame(8'h46, 8'h00, 8'h00);
        check("f0000_data", 32'(tx_data), 32'h06);
        handshake();
        sw_0 = 1'b1;
        sw_1 = 1'b1;
        repeat (3) tick();
        strobe();
        check("sw11_phase1", 32'(phase), 32'h1534);
        tick();
        strobe();
        check("sw11_phase2", 32'(phase), 32'h1734);
        tick();

        // ---------------- amplitude, status, unknown ----------------
        send_frame(8'h41, 8'h00, 8'h20);
        check("amp_ack", 32'(tx_data), 32'h06);
        handshake();
        check("amp_value", 32'(amplitude), 32'h20);
        send_frame(8'h53, 8'h00, 8'h00);
        check("stat_data", 32'(tx_data), 32'h20);
        check("stat_valid", 32'(tx_valid), 32'h1);
        handshake();
        send_frame(8'h7A, 8'h00, 8'h00);
        check("nak_data", 32'(tx_data), 32'h15);
        handshake();
        check("nak_amp", 32'(amplitude), 32'h20);
        check("nak_gen_en", 32'(gen_en), 32'h1);
        strobe();
        check("nak_phase", 32'(phase), 32'h1934);
        tick();

        // ---------------- generator disable / enable ----------------
        send_frame(8'h45, 8'h00, 8'h00);
        check("dis_ack", 32'(tx_data), 32'h06);
        handshake();
        check("dis_gen_en", 32'(gen_en), 32'h0);
        check("dis_phase", 32'(phase), 32'h0000);
        strobe();
        check("dis_step_phase", 32'(phase), 32'h0000);
        check("dis_step_req", 32'(sample_req), 32'h0);
        tick();
        send_frame(8'h45, 8'h00, 8'h01);
        handshake();
        check("en_gen_en", 32'(gen_en), 32'h1);
        strobe();
        check("en_phase", 32'(phase), 32'h0200);
        check("en_req", 32'(sample_req), 32'h1);
        tick();

        // ---------------- inter-byte timeout ----------------
        send_byte(8'h46);
        repeat (1005) tick();
        check("to_no_resp", 32'(tx_valid), 32'h0);
        send_frame(8'h41, 8'h00, 8'h55);
        check("to_next_ack", 32'(tx_data), 32'h06);
        handshake();
        check("to_next_amp", 32'(amplitude), 32'h55);
        strobe();
        check("to_next_phase", 32'(phase), 32'h0400);
        tick();

        // ---------------- reset during RESP ----------------
        send_frame(8'h46, 8'h00, 8'h10);
        check("rr_pending", 32'(tx_valid), 32'h1);
        rst = 1'b1;
        tick();
        check("rr_tx_valid", 32'(tx_valid), 32'h0);
        check("rr_tx_data", 32'(tx_data), 32'h00);
        check("rr_phase", 32'(phase), 32'h0000);
        check("rr_amplitude", 32'(amplitude), 32'h80);
        check("rr_gen_en", 32'(gen_en), 32'h1);
        check("rr_sample_req", 32'(sample_req), 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        strobe();
        check("rr_override_off", 32'(phase), 32'h0200);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
